// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STRB_W = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic              we;
    logic [STRB_W-1:0] wstrb;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
  } mem_bus_t;

  function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Access checking, store lane replication and load extraction/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [XLEN-1:0]   store_data,
  input  logic [XLEN-1:0]   rdata,
  output logic              fault_c,
  output logic [STRB_W-1:0] wstrb_c,
  output logic [XLEN-1:0]   wdata_c,
  output logic [XLEN-1:0]   rdata_ext_c
);

  logic        illegal;
  logic        misaligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (funct3)
      F3_B, F3_BU: misaligned = 1'b0;
      F3_H, F3_HU: misaligned = addr_lo[0];
      F3_W:        misaligned = (addr_lo != 2'b00);
      default:     illegal    = 1'b1;
    endcase
    // Stores have no unsigned variants.
    if (is_store && funct3[2]) begin
      illegal = 1'b1;
    end
    fault_c = illegal | misaligned;
  end

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    rdata_ext_c = rdata;
    case (funct3)
      F3_B:    rdata_ext_c = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   rdata_ext_c = {24'd0, byte_sel};
      F3_H:    rdata_ext_c = {{16{half_sel[15]}}, half_sel};
      F3_HU:   rdata_ext_c = {16'd0, half_sel};
      default: rdata_ext_c = rdata;
    endcase
  end

  always_comb begin
    wdata_c = store_data;
    wstrb_c = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        wdata_c = {4{store_data[7:0]}};
        wstrb_c = 4'b0001 << addr_lo;
      end
      2'b01: begin
        wdata_c = {2{store_data[15:0]}};
        wstrb_c = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_c = store_data;
        wstrb_c = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/lsu_unit.sv
// Single-access load/store unit: IDLE -> REQ -> RESP with bus timeout.
module lsu_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   store_data,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [XLEN-1:0]   load_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_ready,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              is_store_q, is_store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic              skip_q, skip_d;
  logic              req_q, req_d;
  logic              fault_q, fault_d;
  logic [XLEN-1:0]   load_data_q, load_data_d;
  mem_bus_t          bus_q, bus_d;

  logic              idle;
  logic [2:0]        al_funct3;
  logic [1:0]        al_addr_lo;
  logic              al_is_store;
  logic              al_fault;
  logic [STRB_W-1:0] al_wstrb;
  logic [XLEN-1:0]   al_wdata;
  logic [XLEN-1:0]   al_rdata_ext;

  // Checks/lanes use the live inputs in IDLE, the latched access otherwise.
  assign idle        = (state_q == S_IDLE);
  assign al_is_store = idle ? is_store : is_store_q;
  assign al_funct3   = idle ? funct3 : funct3_q;
  assign al_addr_lo  = idle ? addr[1:0] : addr_lo_q;

  lsu_align u_align (
    .is_store    (al_is_store),
    .funct3      (al_funct3),
    .addr_lo     (al_addr_lo),
    .store_data  (store_data),
    .rdata       (mem_rdata),
    .fault_c     (al_fault),
    .wstrb_c     (al_wstrb),
    .wdata_c     (al_wdata),
    .rdata_ext_c (al_rdata_ext)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    skip_d      = skip_q;
    req_d       = req_q;
    fault_d     = fault_q;
    load_data_d = load_data_q;
    bus_d       = bus_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_store_d = is_store;
          funct3_d   = funct3;
          addr_lo_d  = addr[1:0];
          cnt_d      = '0;
          state_d    = S_REQ;
          // A rejected access spends its REQ cycle with the request suppressed.
          if (al_fault) begin
            skip_d = 1'b1;
            req_d  = 1'b0;
          end else begin
            skip_d      = 1'b0;
            req_d       = 1'b1;
            bus_d.addr  = word_addr(addr);
            bus_d.wdata = al_wdata;
            bus_d.wstrb = is_store ? al_wstrb : '0;
            bus_d.we    = is_store;
          end
        end
      end

      S_REQ: begin
        if (skip_q) begin
          state_d = S_RESP;
          fault_d = 1'b1;
          skip_d  = 1'b0;
        end else if (mem_ready) begin
          state_d = S_RESP;
          fault_d = 1'b0;
          if (!is_store_q) begin
            load_data_d = al_rdata_ext;
          end
          req_d       = 1'b0;
          bus_d.we    = 1'b0;
          bus_d.wstrb = '0;
        end else begin
          cnt_d = cnt_inc;
          if ((TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT))) begin
            state_d     = S_RESP;
            fault_d     = 1'b1;
            req_d       = 1'b0;
            bus_d.we    = 1'b0;
            bus_d.wstrb = '0;
          end
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        skip_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      is_store_q  <= 1'b0;
      funct3_q    <= '0;
      addr_lo_q   <= '0;
      skip_q      <= 1'b0;
      req_q       <= 1'b0;
      fault_q     <= 1'b0;
      load_data_q <= '0;
      bus_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_store_q  <= is_store_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      skip_q      <= skip_d;
      req_q       <= req_d;
      fault_q     <= fault_d;
      load_data_q <= load_data_d;
      bus_q       <= bus_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_RESP);
  assign fault     = fault_q;
  assign load_data = load_data_q;
  assign mem_req   = req_q;
  assign mem_we    = bus_q.we;
  assign mem_addr  = bus_q.addr;
  assign mem_wdata = bus_q.wdata;
  assign mem_wstrb = bus_q.wstrb;

endmodule

// File: doc/lsu_unit.md
# lsu_unit

Load/store unit sitting directly downstream of `alu_unit`: it takes the effective address produced on `addr_alu_out`, the store operand (`rs2`), and `funct3`, and performs one data-memory access over a simple req/ready bus. It checks alignment, drives byte-lane strobes, and sign- or zero-extends load data. It returns a registered result with a one-cycle `done` pulse for writeback.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum number of cycles spent waiting for `mem_ready`. 0 disables the timeout.

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin an access; sampled only in IDLE
- `is_store`  in  1  1 = store, 0 = load
- `funct3`  in  3  access type: 0 B, 1 H, 2 W, 4 BU, 5 HU (loads); 0 SB, 1 SH, 2 SW (stores)
- `addr`  in  32  effective address (from `addr_alu_out`)
- `store_data`  in  32  store operand (rs2)
- `busy`  out  1  high whenever state ≠ IDLE
- `done`  out  1  one-cycle completion pulse
- `fault`  out  1  valid with `done`: misaligned access, illegal `funct3`, or timeout
- `load_data`  out  32  extended load result; held until the next `done`
- `mem_req`  out  1  bus request
- `mem_we`  out  1  write enable
- `mem_addr`  out  32  word address (`{addr[31:2],2'b00}`)
- `mem_wdata`  out  32  lane-replicated store data
- `mem_wstrb`  out  4  byte strobes (0 for loads)
- `mem_ready`  in  1  bus accepts/completes in the same cycle
- `mem_rdata`  in  32  read data, valid when `mem_req && mem_ready`

## Operation
- States: IDLE, REQ, RESP.
- IDLE + `start`:
  - Latch `is_store`, `funct3`, `addr`, `store_data`, `addr[1:0]`.
  - Illegal `funct3` (3, 6, 7 for loads; ≥3 for stores) or misalignment (H with `addr[0]`=1; W with `addr[1:0]`≠0): go to RESP with fault=1 and no bus request.
  - Otherwise go to REQ.
- REQ: `mem_req`=1 and bus outputs stable. When `mem_ready`=1, capture and extend `mem_rdata` (loads) and go to RESP. When the wait counter reaches `TIMEOUT`, go to RESP with fault=1, drop `mem_req`, and leave `load_data` unchanged.
- RESP: `done`=1 for one cycle, then IDLE.
- Load extract: byte at lane `addr[1:0]`, half at `addr[1]`; sign-extend for B/H, zero-extend for BU/HU/W.
- Store lanes:
  - SB: wdata = `{4{b}}`, wstrb = `1<<addr[1:0]`.
  - SH: wdata = `{2{h}}`, wstrb = `addr[1] ? 4'b1100 : 4'b0011`.
  - SW: wstrb = `4'b1111`.
- `start` while busy: ignored, no queueing.
- `fault` and `load_data` are registered and updated only on entry to RESP.

## Timing
- Reset values: state IDLE; `busy`, `done`, `fault`, `mem_req`, `mem_we` = 0; `mem_wstrb`=0; `mem_addr`, `mem_wdata`, `load_data` = 0; wait counter 0.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- Cycle 0: `start` sampled. Cycle 1: `mem_req` high. If `mem_ready` is high in cycle 1, `done` is high in cycle 2.
  - Minimum latency from `start` to `done`: 2 cycles.
  - Fault without a bus request: also 2 cycles.
- Wait counter:
  - Cleared on entry to REQ.
  - Increments each REQ cycle with `mem_ready`=0.
  - Timeout fires when the count equals `TIMEOUT`, so at most `TIMEOUT` request cycles occur before RESP.
- `mem_ready` is ignored outside REQ.
- `rst` mid-REQ: `mem_req` drops asynchronously, no `done` is produced, and the pending access is abandoned.

## Structure
- Package `lsu_pkg`: `funct3` constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`) and state encoding (`S_IDLE`, `S_REQ`, `S_RESP`).
- Sub-module `lsu_align`: combinational; computes misalignment and illegal-`funct3` detection, `mem_wstrb`/`mem_wdata` lane generation, and load extract/extension. The FSM and counter stay in `lsu_unit`.

## Test plan
- LB: `addr`=0x103, `mem_rdata`=0x80FF_1234, `mem_ready` high immediately → `load_data`=0xFFFF_FF80, `done` at cycle 2, `fault`=0.
- LHU: `addr`=0x102, `mem_rdata`=0x8001_0000 → `load_data`=0x0000_8001. LW at 0x104 with rdata 0xDEAD_BEEF → 0xDEAD_BEEF.
- SH: `addr`=0x2, `store_data`=0x1234_ABCD → `mem_addr`=0x0, `mem_wdata`=0xABCD_ABCD, `mem_wstrb`=4'b1100, `mem_we`=1.
- LW at `addr`=0x101 → `mem_req` never asserted; `done`=1 and `fault`=1 at cycle 2; `load_data` unchanged.
- `TIMEOUT`=4, `mem_ready` held low → exactly 4 cycles with `mem_req` high, then `done` with `fault`=1. A second `start` pulsed during REQ is ignored.
- Assert `rst` while in REQ → `mem_req`/`busy` drop in the same cycle, no `done` follows, and a fresh `start` after reset completes normally.
